// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct encodings, FSM states and size helpers for dmem_access_unit
package dmem_pkg;

    localparam logic [2:0] FUNCT_B  = 3'b000;
    localparam logic [2:0] FUNCT_H  = 3'b001;
    localparam logic [2:0] FUNCT_W  = 3'b010;
    localparam logic [2:0] FUNCT_BU = 3'b100;
    localparam logic [2:0] FUNCT_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC1,
        ST_ACC2,
        ST_RESP
    } state_t;

    // Access size in bytes; 0 marks an illegal funct code.
    function automatic logic [2:0] size_of_funct(input logic [2:0] funct);
        case (funct)
            FUNCT_B, FUNCT_BU: return 3'd1;
            FUNCT_H, FUNCT_HU: return 3'd2;
            FUNCT_W:           return 3'd4;
            default:           return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] base_lanes(input logic [2:0] funct);
        case (size_of_funct(funct))
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct, input logic [1:0] off);
        return ({2'b00, off} + {1'b0, size_of_funct(funct)}) > 4'd4;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects load bytes from up to two captured words and sign/zero-extends them
import dmem_pkg::*;

module dmem_load_align (
    input  logic [31:0] word_lo,
    input  logic [31:0] word_hi,
    input  logic [1:0]  off,
    input  logic [2:0]  funct,
    output logic [31:0] rdata
);

    logic [31:0] raw;

    always_comb begin
        // Bytes past the first word come from the low lanes of word_hi.
        raw = 32'({word_hi, word_lo} >> {off, 3'b000});
        case (funct)
            FUNCT_B:  rdata = {{24{raw[7]}}, raw[7:0]};
            FUNCT_BU: rdata = {24'b0, raw[7:0]};
            FUNCT_H:  rdata = {{16{raw[15]}}, raw[15:0]};
            FUNCT_HU: rdata = {16'b0, raw[15:0]};
            FUNCT_W:  rdata = raw;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - load/store front end for the byte-enabled 32-bit data memory
// DMEM_MISALIGN_SPLIT_EN: split misaligned accesses over two words instead of faulting them.
import dmem_pkg::*;

module dmem_access_unit #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [3:0]        mem_byteena,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-3:0] mem_rdaddress,
    output logic [ADDR_W-3:0] mem_wraddress,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int WA_W = ADDR_W - 2;

    state_t            state, state_n;
    logic              r_we, r_we_n;
    logic [2:0]        r_funct, r_funct_n;
    logic [1:0]        r_off, r_off_n;
    logic              r_err, r_err_n;
    logic              req_fault;
    logic [3:0]        mem_byteena_n;
    logic [DATA_W-1:0] mem_data_n;
    logic [WA_W-1:0]   mem_rdaddress_n, mem_wraddress_n;
    logic              mem_wren_n;
    logic              resp_valid_n, resp_err_n;
    logic [DATA_W-1:0] resp_rdata_n;
    logic [31:0]       align_lo, align_hi, load_data;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [WA_W-1:0]   r_word, r_word_n;
    logic [31:0]       r_wdata, r_wdata_n;
    logic [31:0]       word0_q, word0_n;

    function automatic logic [3:0] split_lanes(input logic [2:0] funct, input logic [1:0] off,
                                               input logic hi);
        logic [7:0] m;
        m = {4'b0000, base_lanes(funct)} << off;
        return hi ? m[7:4] : m[3:0];
    endfunction

    function automatic logic [31:0] split_data(input logic [31:0] wdata, input logic [1:0] off,
                                               input logic hi);
        logic [63:0] d;
        d = {32'b0, wdata} << {off, 3'b000};
        return hi ? d[63:32] : d[31:0];
    endfunction

    assign req_fault = (size_of_funct(req_funct) == 3'd0);
    assign align_lo  = (state == ST_ACC2) ? word0_q : mem_q;
    assign align_hi  = (state == ST_ACC2) ? mem_q : 32'b0;
`else
    assign req_fault = (size_of_funct(req_funct) == 3'd0) || is_misaligned(req_funct, req_addr[1:0]);
    assign align_lo  = mem_q;
    assign align_hi  = 32'b0;
`endif

    assign req_ready = (state == ST_IDLE);

    dmem_load_align u_align (
        .word_lo (align_lo),
        .word_hi (align_hi),
        .off     (r_off),
        .funct   (r_funct),
        .rdata   (load_data)
    );

    always_comb begin
        state_n         = state;
        r_we_n          = r_we;
        r_funct_n       = r_funct;
        r_off_n         = r_off;
        r_err_n         = r_err;
`ifdef DMEM_MISALIGN_SPLIT_EN
        r_word_n        = r_word;
        r_wdata_n       = r_wdata;
        word0_n         = word0_q;
`endif
        mem_byteena_n   = '0;
        mem_data_n      = '0;
        mem_rdaddress_n = '0;
        mem_wraddress_n = '0;
        mem_wren_n      = 1'b0;
        resp_valid_n    = 1'b0;
        resp_err_n      = 1'b0;
        resp_rdata_n    = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    r_we_n    = req_we;
                    r_funct_n = req_funct;
                    r_off_n   = req_addr[1:0];
                    r_err_n   = req_fault;
`ifdef DMEM_MISALIGN_SPLIT_EN
                    r_word_n  = req_addr[ADDR_W-1:2];
                    r_wdata_n = req_wdata;
`endif
                    // Faults still pass through ACC1, idle on the memory, to keep
                    // the response in the same cycle as an aligned access.
                    state_n   = ST_ACC1;
                    if (!req_fault) begin
                        mem_rdaddress_n = req_addr[ADDR_W-1:2];
                        mem_wraddress_n = req_addr[ADDR_W-1:2];
                        mem_wren_n      = req_we;
`ifdef DMEM_MISALIGN_SPLIT_EN
                        mem_byteena_n   = split_lanes(req_funct, req_addr[1:0], 1'b0);
                        mem_data_n      = split_data(req_wdata, req_addr[1:0], 1'b0);
`else
                        mem_byteena_n   = base_lanes(req_funct) << req_addr[1:0];
                        mem_data_n      = req_wdata << {req_addr[1:0], 3'b000};
`endif
                    end
                end
            end
            ST_ACC1: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                if (!r_err && is_misaligned(r_funct, r_off)) begin
                    state_n         = ST_ACC2;
                    word0_n         = mem_q;
                    mem_rdaddress_n = r_word + WA_W'(1);
                    mem_wraddress_n = r_word + WA_W'(1);
                    mem_wren_n      = r_we;
                    mem_byteena_n   = split_lanes(r_funct, r_off, 1'b1);
                    mem_data_n      = split_data(r_wdata, r_off, 1'b1);
                end else begin
                    state_n      = ST_RESP;
                    resp_valid_n = 1'b1;
                    resp_err_n   = r_err;
                    resp_rdata_n = (r_we || r_err) ? '0 : load_data;
                end
`else
                state_n      = ST_RESP;
                resp_valid_n = 1'b1;
                resp_err_n   = r_err;
                resp_rdata_n = (r_we || r_err) ? '0 : load_data;
`endif
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            ST_ACC2: begin
                state_n      = ST_RESP;
                resp_valid_n = 1'b1;
                resp_rdata_n = r_we ? '0 : load_data;
            end
`endif
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            r_we          <= 1'b0;
            r_funct       <= '0;
            r_off         <= '0;
            r_err         <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            r_word        <= '0;
            r_wdata       <= '0;
            word0_q       <= '0;
`endif
            mem_byteena   <= '0;
            mem_data      <= '0;
            mem_rdaddress <= '0;
            mem_wraddress <= '0;
            mem_wren      <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
        end else begin
            state         <= state_n;
            r_we          <= r_we_n;
            r_funct       <= r_funct_n;
            r_off         <= r_off_n;
            r_err         <= r_err_n;
`ifdef DMEM_MISALIGN_SPLIT_EN
            r_word        <= r_word_n;
            r_wdata       <= r_wdata_n;
            word0_q       <= word0_n;
`endif
            mem_byteena   <= mem_byteena_n;
            mem_data      <= mem_data_n;
            mem_rdaddress <= mem_rdaddress_n;
            mem_wraddress <= mem_wraddress_n;
            mem_wren      <= mem_wren_n;
            resp_valid    <= resp_valid_n;
            resp_err      <= resp_err_n;
            resp_rdata    <= resp_rdata_n;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - randomized self-checking bench for dmem_access_unit against a byte-level memory model
module tb_dmem_access_unit;

    logic        clock = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data;
    logic [14:0] mem_rdaddress;
    logic [14:0] mem_wraddress;
    logic        mem_wren;
    logic [31:0] mem_q;

    int checks = 0;
    int failures = 0;

    logic [31:0] bmem  [0:32767];
    logic [7:0]  ref_b [0:131071];

    always #5 clock = ~clock;

    assign mem_q = bmem[mem_rdaddress];

    always @(posedge clock) begin
        if (mem_wren)
            for (int j = 0; j < 4; j++)
                if (mem_byteena[j]) bmem[mem_wraddress][8*j +: 8] = mem_data[8*j +: 8];
    end

    dmem_access_unit #(.ADDR_W(17), .DATA_W(32)) dut (
        .clock         (clock),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct     (req_funct),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_byteena   (mem_byteena),
        .mem_data      (mem_data),
        .mem_rdaddress (mem_rdaddress),
        .mem_wraddress (mem_wraddress),
        .mem_wren      (mem_wren),
        .mem_q         (mem_q)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Issues one request and checks latency, memory traffic and response against the byte model.
    task automatic do_req(input logic we, input logic [2:0] f, input logic [16:0] a, input logic [31:0] wd,
                          output logic [31:0] rd_o, output logic err_o,
                          output logic [3:0] be1_o, output logic [31:0] data1_o,
                          output logic [14:0] addr1_o, output logic [14:0] addr2_o);
        int sz, exp_acc, exp_lat, n_acc, n_wren, n_busy, n_addr, lat;
        logic mis, exp_err;
        logic [31:0] raw, exp_rd, edata, emask;
        logic [16:0] ba, d;
        logic [14:0] w;
        logic [3:0] m;
        logic [14:0] acc_addr [2];
        logic [3:0]  acc_be   [2];
        logic [31:0] acc_data [2];
        sz  = size_bytes(f);
        mis = (sz != 0) && (int'(a[1:0]) + sz > 4);
`ifdef DMEM_MISALIGN_SPLIT_EN
        exp_err = (sz == 0);
`else
        exp_err = (sz == 0) || mis;
`endif
        exp_acc = exp_err ? 0 : (mis ? 2 : 1);
        exp_lat = (exp_acc == 2) ? 3 : 2;
        raw = '0;
        for (int i = 0; i < sz; i++) begin
            ba = a + 17'(i);
            raw[8*i +: 8] = ref_b[ba];
        end
        case (f)
            3'd0:    exp_rd = {{24{raw[7]}}, raw[7:0]};
            3'd1:    exp_rd = {{16{raw[15]}}, raw[15:0]};
            default: exp_rd = raw;
        endcase
        if (we) exp_rd = '0;
        for (int j = 0; j < 2; j++) begin
            acc_addr[j] = '0; acc_be[j] = '0; acc_data[j] = '0;
        end

        @(negedge clock);
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct = f; req_addr = a; req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct = 3'($urandom);
        req_addr = 17'($urandom); req_wdata = $urandom;
        n_acc = 0; n_wren = 0; n_busy = 0; n_addr = 0; lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = k;
                break;
            end
            if (req_ready) n_busy++;
            if (mem_wren) n_wren++;
            if (mem_byteena != 4'b0) begin
                if (n_acc < 2) begin
                    acc_addr[n_acc] = mem_rdaddress;
                    acc_be[n_acc]   = mem_byteena;
                    acc_data[n_acc] = mem_data;
                end
                if (mem_wraddress != mem_rdaddress) n_addr++;
                n_acc++;
            end
        end
        rd_o = resp_rdata; err_o = resp_err;
        be1_o = acc_be[0]; data1_o = acc_data[0]; addr1_o = acc_addr[0]; addr2_o = acc_addr[1];
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("n_access", 32'(n_acc), 32'(exp_acc));
        check_eq("n_wren", 32'(n_wren), (we && !exp_err) ? 32'(exp_acc) : 32'd0);
        check_eq("busy_ready", 32'(n_busy), 32'd0);
        check_eq("rd_wr_addr", 32'(n_addr), 32'd0);
        check_eq("resp_err", 32'(resp_err), 32'(exp_err));
        if (!exp_err) check_eq("resp_rdata", resp_rdata, exp_rd);
        for (int j = 0; j < exp_acc && j < n_acc; j++) begin
            w = a[16:2] + 15'(j);
            m = '0; edata = '0; emask = '0;
            for (int l = 0; l < 4; l++) begin
                d = {w, 2'(l)} - a;
                if (int'(d) < sz) begin
                    m[l] = 1'b1;
                    emask[8*l +: 8] = 8'hFF;
                    edata[8*l +: 8] = wd[8*int'(d) +: 8];
                end
            end
            check_eq("acc_addr", 32'(acc_addr[j]), 32'(w));
            check_eq("acc_byteena", 32'(acc_be[j]), 32'(m));
            if (we) check_eq("acc_data", acc_data[j] & emask, edata);
        end
        @(negedge clock);
        check_eq("resp_pulse", 32'(resp_valid), 32'd0);
        if (we && !exp_err)
            for (int i = 0; i < sz; i++) begin
                ba = a + 17'(i);
                ref_b[ba] = wd[8*i +: 8];
            end
    endtask

    logic [31:0] rd, d1;
    logic        er;
    logic [3:0]  be1;
    logic [14:0] a1, a2;
    logic [2:0]  ftab [5];
    logic [31:0] v;
    int          word;

    initial begin
        ftab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int w = 0; w < 32768; w++) begin
            v = $urandom;
            bmem[w] = v;
            for (int j = 0; j < 4; j++) ref_b[4*w + j] = v[8*j +: 8];
        end
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_mem_wren", 32'(mem_wren), 32'd0);
        check_eq("rst_byteena", 32'(mem_byteena), 32'd0);
        check_eq("rst_mem_data", mem_data, 32'd0);
        check_eq("rst_rdaddr", 32'(mem_rdaddress), 32'd0);
        check_eq("rst_wraddr", 32'(mem_wraddress), 32'd0);
        rstn = 1'b1;

        do_req(1'b1, 3'd2, 17'h00010, 32'hDEADBEEF, rd, er, be1, d1, a1, a2);
        check_eq("sw_be", 32'(be1), 32'hF);
        check_eq("sw_addr", 32'(a1), 32'd4);
        check_eq("sw_data", d1, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 17'h00013, 32'h000000A5, rd, er, be1, d1, a1, a2);
        check_eq("sb_be", 32'(be1), 32'h8);
        check_eq("sb_data", d1, 32'hA5000000);
        do_req(1'b0, 3'd0, 17'h00013, 32'h0, rd, er, be1, d1, a1, a2);
        check_eq("lb_rdata", rd, 32'hFFFFFFA5);
        do_req(1'b0, 3'd4, 17'h00013, 32'h0, rd, er, be1, d1, a1, a2);
        check_eq("lbu_rdata", rd, 32'h000000A5);
        do_req(1'b1, 3'd2, 17'h00000, 32'h80011234, rd, er, be1, d1, a1, a2);
        do_req(1'b0, 3'd1, 17'h00002, 32'h0, rd, er, be1, d1, a1, a2);
        check_eq("lh_rdata", rd, 32'hFFFF8001);
        do_req(1'b0, 3'd5, 17'h00002, 32'h0, rd, er, be1, d1, a1, a2);
        check_eq("lhu_rdata", rd, 32'h00008001);
        do_req(1'b1, 3'd2, 17'h1FFFC, 32'h11223344, rd, er, be1, d1, a1, a2);
        do_req(1'b1, 3'd2, 17'h00000, 32'h55667788, rd, er, be1, d1, a1, a2);
        do_req(1'b0, 3'd2, 17'h1FFFE, 32'h0, rd, er, be1, d1, a1, a2);
`ifdef DMEM_MISALIGN_SPLIT_EN
        check_eq("lw_wrap_err", 32'(er), 32'd0);
        check_eq("lw_wrap_addr1", 32'(a1), 32'h7FFF);
        check_eq("lw_wrap_addr2", 32'(a2), 32'h0000);
        check_eq("lw_wrap_rdata", rd, 32'h77881122);
`else
        check_eq("lw_mis_err", 32'(er), 32'd1);
`endif
        do_req(1'b0, 3'd3, 17'h00004, 32'h0, rd, er, be1, d1, a1, a2);
        check_eq("illegal_ld_err", 32'(er), 32'd1);
        do_req(1'b1, 3'd3, 17'h00008, 32'hCAFEF00D, rd, er, be1, d1, a1, a2);
        check_eq("illegal_st_err", 32'(er), 32'd1);

        // Reset while a store sits in ACC1: the write must vanish with no response.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_funct = 3'd2; req_addr = 17'h00020; req_wdata = 32'h0BADF00D;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check_eq("acc1_wren", 32'(mem_wren), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("rst_drop_wren", 32'(mem_wren), 32'd0);
        check_eq("rst_drop_byteena", 32'(mem_byteena), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        rstn = 1'b1;
        @(negedge clock);
        check_eq("rst_ready_after", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'd2, 17'h00020, 32'h0, rd, er, be1, d1, a1, a2);

        for (int t = 0; t < 300; t++) begin
            word = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : 32760 + $urandom_range(0, 7);
            do_req(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? 3'(3 + 3 * $urandom_range(0, 1) + $urandom_range(0, 1)) :
                                                 ftab[$urandom_range(0, 4)],
                   {15'(word), 2'($urandom_range(0, 3))}, $urandom, rd, er, be1, d1, a1, a2);
        end

        for (int w = 0; w < 32768; w++) begin
            if (w < 16 || w >= 32760) begin
                for (int j = 0; j < 4; j++) v[8*j +: 8] = ref_b[4*w + j];
                check_eq($sformatf("mem_word_%0d", w), bmem[w], v);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
